// File: rtl/aiep_io_pkg.sv
// Shared constants and types for the AIEP user-board input conditioning path.
package aiep_io_pkg;

    localparam int unsigned N_KEY  = 3;
    localparam int unsigned N_SW   = 3;
    localparam int unsigned N_CH   = N_KEY + N_SW;
    localparam int unsigned CLK_HZ = 50_000_000;

    // 20 ms debounce, 1 s first hold, 250 ms auto-repeat at CLK_HZ
    localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
    localparam int unsigned HOLD_CYCLES_DEF     = CLK_HZ;
    localparam int unsigned REPEAT_CYCLES_DEF   = CLK_HZ / 4;
    localparam int unsigned CNT_W_DEF           = 26;

    localparam logic [N_CH-1:0] STATE_IDLE = 6'b111111;

    typedef enum logic {
        HOLD_ARM,
        HOLD_REPEAT
    } hold_phase_e;

endpackage

// File: rtl/aiep_debounce_chan.sv
// One input channel: 2-FF synchroniser followed by a persistence-counter debouncer.
module aiep_debounce_chan
    import aiep_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] dcnt;
    logic             accept;

    assign accept = (s2 != level_o) && (dcnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // rise_o/fall_o flag the edge on which level_o will take the new value,
    // so the parent can register its pulses in step with the level update.
    assign rise_o = accept & s2;
    assign fall_o = accept & ~s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= raw_i;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_o <= 1'b1;
            dcnt    <= '0;
        end else if (s2 == level_o) begin
            dcnt <= '0;
        end else if (accept) begin
            level_o <= s2;
            dcnt    <= '0;
        end else begin
            dcnt <= dcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aiep_input_conditioner.sv
// Debounced KEY/SW levels plus per-key press/release/hold event pulses.
module aiep_input_conditioner
    import aiep_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic              fpga_clk_50,
    input  logic              fpga_rst_n,
    input  logic [N_KEY-1:0]  usr_key_i,
    input  logic [N_SW-1:0]   usr_sw_i,
    output logic [N_CH-1:0]   state_o,
    output logic              state_changed_o,
    output logic [N_KEY-1:0]  key_press_o,
    output logic [N_KEY-1:0]  key_release_o,
    output logic [N_KEY-1:0]  key_hold_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 2);
    localparam logic [CNT_W-1:0] REP_LAST  =
        (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);

    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  level;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_KEY-1:0] key_lvl;
    logic [N_KEY-1:0] key_rise;
    logic [N_KEY-1:0] key_fall;
    logic [N_KEY-1:0] held;

    hold_phase_e      phase_q [N_KEY];
    hold_phase_e      phase_d [N_KEY];
    logic [CNT_W-1:0] hcnt_q  [N_KEY];
    logic [CNT_W-1:0] hcnt_d  [N_KEY];
    logic [N_KEY-1:0] hold_d;

    assign raw = {usr_key_i, usr_sw_i};

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        aiep_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk    (fpga_clk_50),
            .rst_n  (fpga_rst_n),
            .raw_i  (raw[g]),
            .level_o(level[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g])
        );
    end

    assign state_o  = level;
    assign key_lvl  = level[N_CH-1:N_SW];
    assign key_rise = rise[N_CH-1:N_SW];
    assign key_fall = fall[N_CH-1:N_SW];

    // A key in its release-acceptance cycle is no longer held, so no hold
    // pulse can coincide with key_release_o.
    assign held = ~key_lvl & ~key_rise;

    always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_changed_o <= 1'b0;
            key_press_o     <= '0;
            key_release_o   <= '0;
        end else begin
            state_changed_o <= |(rise | fall);
            key_press_o     <= key_fall;
            key_release_o   <= key_rise;
        end
    end

    always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            for (int unsigned k = 0; k < N_KEY; k++) begin
                phase_q[k] <= HOLD_ARM;
                hcnt_q[k]  <= '0;
            end
            key_hold_o <= '0;
        end else begin
            for (int unsigned k = 0; k < N_KEY; k++) begin
                phase_q[k] <= phase_d[k];
                hcnt_q[k]  <= hcnt_d[k];
            end
            key_hold_o <= hold_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_KEY; k++) begin
            phase_d[k] = phase_q[k];
            hcnt_d[k]  = hcnt_q[k];
            if (!held[k]) begin
                phase_d[k] = HOLD_ARM;
                hcnt_d[k]  = '0;
            end else if (hold_d[k]) begin
                phase_d[k] = HOLD_REPEAT;
                hcnt_d[k]  = '0;
            end else if (phase_q[k] == HOLD_ARM || REPEAT_CYCLES != 0) begin
                hcnt_d[k] = hcnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        hold_d = '0;
        for (int unsigned k = 0; k < N_KEY; k++) begin
            if (held[k]) begin
                if (phase_q[k] == HOLD_ARM) begin
                    hold_d[k] = (hcnt_q[k] == HOLD_LAST);
                end else if (REPEAT_CYCLES != 0) begin
                    hold_d[k] = (hcnt_q[k] == REP_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_aiep_input_conditioner.sv
// Scoreboard bench for aiep_input_conditioner with short debounce/hold periods.
module tb_aiep_input_conditioner;

    logic       fpga_clk_50 = 1'b0;
    logic       fpga_rst_n;
    logic [2:0] usr_key_i;
    logic [2:0] usr_sw_i;
    logic [5:0] state_o;
    logic       state_changed_o;
    logic [2:0] key_press_o;
    logic [2:0] key_release_o;
    logic [2:0] key_hold_o;

    typedef struct {
        int         cyc;
        logic [5:0] st;
        logic       chg;
        logic [2:0] pr;
        logic [2:0] rl;
        logic [2:0] hd;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    int         cyc       = 0;
    int         n_tests   = 0;
    int         n_fail    = 0;
    logic [5:0] exp_state = 6'b111111;

    aiep_input_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (32),
        .REPEAT_CYCLES  (16),
        .CNT_W          (6)
    ) dut (
        .fpga_clk_50    (fpga_clk_50),
        .fpga_rst_n     (fpga_rst_n),
        .usr_key_i      (usr_key_i),
        .usr_sw_i       (usr_sw_i),
        .state_o        (state_o),
        .state_changed_o(state_changed_o),
        .key_press_o    (key_press_o),
        .key_release_o  (key_release_o),
        .key_hold_o     (key_hold_o)
    );

    always #10 fpga_clk_50 = ~fpga_clk_50;

    always @(posedge fpga_clk_50) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge fpga_clk_50);
        #1;
    endtask

    task automatic push(input int c, input logic [5:0] st, input logic chg,
                        input logic [2:0] pr, input logic [2:0] rl, input logic [2:0] hd);
        ev_t e;
        e.cyc = c;
        e.st  = st;
        e.chg = chg;
        e.pr  = pr;
        e.rl  = rl;
        e.hd  = hd;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] outs();
        return {state_o, state_changed_o, key_press_o, key_release_o, key_hold_o};
    endfunction

    // Monitor: every output pulse must match the next expected event exactly.
    always @(negedge fpga_clk_50) begin
        if (!fpga_rst_n) begin
            exp_state = 6'b111111;
        end else if (state_changed_o || (|key_press_o) || (|key_release_o) || (|key_hold_o)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: cyc=%0d st=%b chg=%b pr=%b rl=%b hd=%b want no pulse",
                         cyc, state_o, state_changed_o, key_press_o, key_release_o, key_hold_o);
            end else begin
                ev = exp_q.pop_front();
                if (ev.cyc != cyc || state_o !== ev.st || state_changed_o !== ev.chg ||
                    key_press_o !== ev.pr || key_release_o !== ev.rl || key_hold_o !== ev.hd) begin
                    n_fail++;
                    $display("FAIL event: got cyc=%0d st=%b chg=%b pr=%b rl=%b hd=%b want cyc=%0d st=%b chg=%b pr=%b rl=%b hd=%b",
                             cyc, state_o, state_changed_o, key_press_o, key_release_o, key_hold_o,
                             ev.cyc, ev.st, ev.chg, ev.pr, ev.rl, ev.hd);
                end
                exp_state = ev.st;
            end
        end else begin
            n_tests++;
            if (state_o !== exp_state) begin
                n_fail++;
                $display("FAIL state_stable: cyc=%0d got %b want %b", cyc, state_o, exp_state);
            end
        end
    end

    initial begin
        int c;
        int a;
        int r;
        fpga_rst_n = 1'b0;
        usr_key_i  = 3'b111;
        usr_sw_i   = 3'b111;
        tick(3);
        check("reset_outputs", outs(), {6'b111111, 10'b0});
        fpga_rst_n = 1'b1;
        tick(100);
        check("idle_100", outs(), {6'b111111, 10'b0});

        // key1 press and release
        c = cyc;
        usr_key_i[1] = 1'b0;
        push(c + 10, 6'b101111, 1'b1, 3'b010, 3'b000, 3'b000);
        tick(20);
        usr_key_i[1] = 1'b1;
        push(cyc + 10, 6'b111111, 1'b1, 3'b000, 3'b010, 3'b000);
        tick(20);

        // exactly 8 low cycles is just long enough to be accepted
        c = cyc;
        usr_key_i[1] = 1'b0;
        tick(8);
        usr_key_i[1] = 1'b1;
        push(c + 10, 6'b101111, 1'b1, 3'b010, 3'b000, 3'b000);
        push(c + 18, 6'b111111, 1'b1, 3'b000, 3'b010, 3'b000);
        tick(20);

        // glitches that must be rejected
        usr_key_i[0] = 1'b0;
        tick(7);
        usr_key_i[0] = 1'b1;
        tick(15);
        usr_key_i[0] = 1'b0;
        tick(5);
        usr_key_i[0] = 1'b1;
        tick(1);
        usr_key_i[0] = 1'b0;
        tick(5);
        usr_key_i[0] = 1'b1;
        tick(15);
        check("glitch_state", outs(), {6'b111111, 10'b0});

        // key2 long hold with auto-repeat
        c = cyc;
        a = c + 10;
        usr_key_i[2] = 1'b0;
        push(a, 6'b011111, 1'b1, 3'b100, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++)
            push(a + 31 + 16 * i, 6'b011111, 1'b0, 3'b000, 3'b000, 3'b100);
        tick(110);
        usr_key_i[2] = 1'b1;
        push(a + 110, 6'b111111, 1'b1, 3'b000, 3'b100, 3'b000);
        tick(30);

        // switches change together: one state_changed_o, no key events
        c = cyc;
        usr_sw_i = 3'b010;
        push(c + 10, 6'b111010, 1'b1, 3'b000, 3'b000, 3'b000);
        tick(20);
        usr_sw_i = 3'b111;
        push(cyc + 10, 6'b111111, 1'b1, 3'b000, 3'b000, 3'b000);
        tick(20);

        // reset while key2 is in hold and key0 is mid-debounce
        c = cyc;
        a = c + 10;
        usr_key_i[2] = 1'b0;
        push(a, 6'b011111, 1'b1, 3'b100, 3'b000, 3'b000);
        push(a + 31, 6'b011111, 1'b0, 3'b000, 3'b000, 3'b100);
        tick(45);
        usr_key_i[0] = 1'b0;
        tick(7);
        fpga_rst_n = 1'b0;
        #1;
        check("reset_async", outs(), {6'b111111, 10'b0});
        tick(3);
        fpga_rst_n = 1'b1;
        r = cyc;
        push(r + 10, 6'b010111, 1'b1, 3'b101, 3'b000, 3'b000);
        tick(15);
        usr_key_i = 3'b111;
        push(cyc + 10, 6'b111111, 1'b1, 3'b000, 3'b101, 3'b000);
        tick(30);
        check("final_idle", outs(), {6'b111111, 10'b0});

        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_event: got nothing want cyc=%0d st=%b chg=%b pr=%b rl=%b hd=%b",
                     ev.cyc, ev.st, ev.chg, ev.pr, ev.rl, ev.hd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
